apb_slave_mux_ctrl: RTL and testbench

- Fabric-side APB3 controller between the MSS APB master port (MSSP*) and up to NUM_SLV fabric peripherals (controller poller, audio, display, etc.).
- Decodes MSSPADDR into one slave select and multiplexes that slave's response back to the MSS.
- Enforces a per-transfer wait-state timeout so a hung peripheral cannot stall the Cortex-M3.
- Records the offending slave in a sticky status for firmware.

---
 rtl/apb_slave_mux_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_apb_slave_mux_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mux_ctrl.sv
// apb_slave_mux_ctrl
//   Fabric-side APB3 controller sitting between the MSS APB master port and
//   up to NUM_SLV fabric peripherals. Decodes the master address into a
//   one-hot slave select, returns the selected slave's response, aborts any
//   transfer whose slave holds PREADY low for TIMEOUT access cycles, and
//   keeps a sticky record of the last slave that timed out.
//
// Ports
//   FAB_CLK, M2F_RESET_N        clock (rising edge), async active-low reset
//   MSSPSEL/ENABLE/WRITE/ADDR/WDATA   APB3 request from the MSS
//   MSSPRDATA/READY/SLVERR      APB3 response to the MSS
//   S_PSEL                      one-hot slave select
//   S_PENABLE/PWRITE/PADDR/PWDATA    broadcast request to all slaves
//   S_PRDATA/PREADY/PSLVERR     per-slave responses (PRDATA packed 32b/slave)
//   TO_FLAG, TO_IDX             sticky timeout status and offending slave
//   TO_CLR                      single-cycle clear of TO_FLAG
module apb_slave_mux_ctrl #(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_LSB = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    FAB_CLK,
  input  logic                    M2F_RESET_N,
  input  logic                    MSSPSEL,
  input  logic                    MSSPENABLE,
  input  logic                    MSSPWRITE,
  input  logic [31:0]             MSSPADDR,
  input  logic [31:0]             MSSPWDATA,
  output logic [31:0]             MSSPRDATA,
  output logic                    MSSPREADY,
  output logic                    MSSPSLVERR,
  output logic [NUM_SLV-1:0]      S_PSEL,
  output logic                    S_PENABLE,
  output logic                    S_PWRITE,
  output logic [SEL_LSB-1:0]      S_PADDR,
  output logic [31:0]             S_PWDATA,
  input  logic [NUM_SLV*32-1:0]   S_PRDATA,
  input  logic [NUM_SLV-1:0]      S_PREADY,
  input  logic [NUM_SLV-1:0]      S_PSLVERR,
  output logic                    TO_FLAG,
  output logic [SEL_W-1:0]        TO_IDX,
  input  logic                    TO_CLR
);

  localparam int unsigned TOP_LSB = SEL_LSB + SEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ABORT  = 2'd3
  } state_e;

  state_e            state_q;
  logic [SEL_W-1:0]  idx_q;
  logic              mapped_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              to_flag_q;
  logic [SEL_W-1:0]  to_idx_q;

  logic [SEL_W-1:0]  idx;
  logic              mapped;
  logic              sl_rdy;
  logic              sl_err;
  logic [31:0]       sl_rdata;
  logic              sel_phase;

  // Address decode on the live master address.
  assign idx    = MSSPADDR[TOP_LSB-1:SEL_LSB];
  assign mapped = (32'(idx) < NUM_SLV) && (MSSPADDR[31:TOP_LSB] == '0);

  assign sel_phase = (state_q == SETUP) || (state_q == ACCESS);

  // Broadcast request paths.
  assign S_PENABLE = MSSPENABLE & MSSPSEL & mapped & (state_q != ABORT);
  assign S_PWRITE  = MSSPWRITE;
  assign S_PWDATA  = MSSPWDATA;
  assign S_PADDR   = MSSPADDR[SEL_LSB-1:0];

  assign TO_FLAG = to_flag_q;
  assign TO_IDX  = to_idx_q;

  // One-hot select from the live index; comparing against each slave number
  // keeps unmapped indices from ever producing an out-of-range bit select.
  always_comb begin
    S_PSEL = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      S_PSEL[i] = MSSPSEL && mapped && sel_phase && (idx == SEL_W'(i));
    end
  end

  // Response of the slave latched at the start of the transfer.
  always_comb begin
    sl_rdy   = 1'b0;
    sl_err   = 1'b0;
    sl_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SEL_W'(i)) begin
        sl_rdy   = S_PREADY[i];
        sl_err   = S_PSLVERR[i];
        sl_rdata = S_PRDATA[32*i +: 32];
      end
    end
  end

  // Master-side response is decided by state; READY must follow the slave in
  // the same cycle, so it cannot come from a register.
  always_comb begin
    MSSPREADY  = 1'b0;
    MSSPSLVERR = 1'b0;
    MSSPRDATA  = '0;
    case (state_q)
      ACCESS: begin
        if (mapped_q) begin
          MSSPREADY  = sl_rdy;
          MSSPSLVERR = sl_err & sl_rdy;
          MSSPRDATA  = sl_rdy ? sl_rdata : '0;
        end else begin
          MSSPREADY  = 1'b1;
          MSSPSLVERR = 1'b1;
        end
      end
      ABORT: begin
        MSSPREADY  = 1'b1;
        MSSPSLVERR = 1'b1;
        MSSPRDATA  = 32'hDEAD_0000 | 32'(idx_q);
      end
      default: ;
    endcase
  end

  // Transfer FSM, wait counter and sticky timeout status.
  // A completed transfer always returns to IDLE; a back-to-back setup cycle
  // from the master is then caught by IDLE on the following cycle, which
  // gives every transfer the same phase alignment as one started from rest.
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mapped_q  <= 1'b0;
      cnt_q     <= '0;
      to_flag_q <= 1'b0;
      to_idx_q  <= '0;
    end else begin
      // A clear is overridden by an abort in the same cycle (assigned below).
      if (TO_CLR) begin
        to_flag_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (MSSPSEL && !MSSPENABLE) begin
            state_q  <= SETUP;
            idx_q    <= idx;
            mapped_q <= mapped;
            cnt_q    <= '0;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (!MSSPSEL || !mapped_q || sl_rdy) begin
            state_q <= IDLE;
          end else begin
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
              state_q <= ABORT;
            end
          end
        end
        ABORT: begin
          state_q   <= IDLE;
          to_flag_q <= 1'b1;
          to_idx_q  <= idx_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mux_ctrl.sv
// Directed testbench for apb_slave_mux_ctrl (TIMEOUT overridden to 15).
module tb_apb_slave_mux_ctrl;

  logic         FAB_CLK = 1'b0;
  logic         M2F_RESET_N;
  logic         MSSPSEL, MSSPENABLE, MSSPWRITE;
  logic [31:0]  MSSPADDR, MSSPWDATA;
  logic [31:0]  MSSPRDATA;
  logic         MSSPREADY, MSSPSLVERR;
  logic [3:0]   S_PSEL;
  logic         S_PENABLE, S_PWRITE;
  logic [7:0]   S_PADDR;
  logic [31:0]  S_PWDATA;
  logic [127:0] S_PRDATA;
  logic [3:0]   S_PREADY, S_PSLVERR;
  logic         TO_FLAG;
  logic [2:0]   TO_IDX;
  logic         TO_CLR;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 FAB_CLK = ~FAB_CLK;

  apb_slave_mux_ctrl #(
    .NUM_SLV(4), .SEL_LSB(8), .SEL_W(3), .TIMEOUT(15), .CNT_W(16)
  ) dut (
    .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N),
    .MSSPSEL(MSSPSEL), .MSSPENABLE(MSSPENABLE), .MSSPWRITE(MSSPWRITE),
    .MSSPADDR(MSSPADDR), .MSSPWDATA(MSSPWDATA),
    .MSSPRDATA(MSSPRDATA), .MSSPREADY(MSSPREADY), .MSSPSLVERR(MSSPSLVERR),
    .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE),
    .S_PADDR(S_PADDR), .S_PWDATA(S_PWDATA),
    .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .TO_FLAG(TO_FLAG), .TO_IDX(TO_IDX), .TO_CLR(TO_CLR)
  );

  // Master setup cycle, then first enable cycle (controller in SETUP).
  task automatic start_xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(posedge FAB_CLK); #1;
    MSSPSEL = 1'b1; MSSPENABLE = 1'b0; MSSPADDR = a; MSSPWRITE = w; MSSPWDATA = d;
    @(posedge FAB_CLK); #1;
    MSSPENABLE = 1'b1;
  endtask

  task automatic end_xfer();
    @(posedge FAB_CLK); #1;
    MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (S_PSEL !== 4'b0) begin n_fail++; $display("FAIL rst_psel got %b exp 0000", S_PSEL); end
    n_tests++; if (MSSPREADY !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", MSSPREADY); end
    n_tests++; if (MSSPSLVERR !== 1'b0) begin n_fail++; $display("FAIL rst_slverr got %b exp 0", MSSPSLVERR); end
    n_tests++; if (MSSPRDATA !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", MSSPRDATA); end
    n_tests++; if (TO_FLAG !== 1'b0) begin n_fail++; $display("FAIL rst_toflag got %b exp 0", TO_FLAG); end
    n_tests++; if (TO_IDX !== 3'd0) begin n_fail++; $display("FAIL rst_toidx got %0d exp 0", TO_IDX); end
    @(posedge FAB_CLK); @(posedge FAB_CLK); #1;
    M2F_RESET_N = 1'b1;
  endtask

  task automatic test_write();
    S_PREADY = 4'b0010;
    start_xfer(32'h0000_0104, 1'b1, 32'h1234_5678);
    @(negedge FAB_CLK);
    n_tests++; if (S_PSEL !== 4'b0010) begin n_fail++; $display("FAIL wr_setup_psel got %b exp 0010", S_PSEL); end
    n_tests++; if (MSSPREADY !== 1'b0) begin n_fail++; $display("FAIL wr_setup_ready got %b exp 0", MSSPREADY); end
    @(posedge FAB_CLK); #1;
    @(negedge FAB_CLK);
    n_tests++; if (MSSPREADY !== 1'b1) begin n_fail++; $display("FAIL wr_ready got %b exp 1", MSSPREADY); end
    n_tests++; if (MSSPSLVERR !== 1'b0) begin n_fail++; $display("FAIL wr_slverr got %b exp 0", MSSPSLVERR); end
    n_tests++; if (S_PSEL !== 4'b0010) begin n_fail++; $display("FAIL wr_psel got %b exp 0010", S_PSEL); end
    n_tests++; if (S_PADDR !== 8'h04) begin n_fail++; $display("FAIL wr_paddr got %h exp 04", S_PADDR); end
    n_tests++; if (S_PWDATA !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_pwdata got %h exp 12345678", S_PWDATA); end
    n_tests++; if ({S_PWRITE, S_PENABLE} !== 2'b11) begin n_fail++; $display("FAIL wr_ctrl got %b exp 11", {S_PWRITE, S_PENABLE}); end
    end_xfer();
    @(negedge FAB_CLK);
    n_tests++; if (S_PSEL !== 4'b0) begin n_fail++; $display("FAIL wr_idle_psel got %b exp 0000", S_PSEL); end
    n_tests++; if (MSSPREADY !== 1'b0) begin n_fail++; $display("FAIL wr_idle_ready got %b exp 0", MSSPREADY); end
  endtask

  task automatic test_wait_read();
    S_PREADY = 4'b0000;
    S_PRDATA[64 +: 32] = 32'hCAFE_F00D;
    start_xfer(32'h0000_0210, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge FAB_CLK); #1;
      S_PREADY[2] = (k == 4);
      @(negedge FAB_CLK);
      n_tests++; if (MSSPREADY !== (k == 4)) begin n_fail++; $display("FAIL rd_ready_c%0d got %b exp %b", k, MSSPREADY, (k == 4)); end
      n_tests++; if (MSSPRDATA !== ((k == 4) ? 32'hCAFE_F00D : 32'h0)) begin n_fail++; $display("FAIL rd_rdata_c%0d got %h", k, MSSPRDATA); end
    end
    n_tests++; if (S_PADDR !== 8'h10) begin n_fail++; $display("FAIL rd_paddr got %h exp 10", S_PADDR); end
    end_xfer();
    S_PREADY = 4'b0000;
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_0500;
    addrs[1] = 32'h0001_0000;
    S_PREADY = 4'b0000;
    for (int t = 0; t < 2; t++) begin
      start_xfer(addrs[t], 1'b0, 32'h0);
      @(negedge FAB_CLK);
      n_tests++; if (S_PSEL !== 4'b0) begin n_fail++; $display("FAIL um%0d_setup_psel got %b exp 0000", t, S_PSEL); end
      @(posedge FAB_CLK); #1;
      @(negedge FAB_CLK);
      n_tests++; if ({MSSPREADY, MSSPSLVERR} !== 2'b11) begin n_fail++; $display("FAIL um%0d_resp got %b exp 11", t, {MSSPREADY, MSSPSLVERR}); end
      n_tests++; if (MSSPRDATA !== 32'h0) begin n_fail++; $display("FAIL um%0d_rdata got %h exp 0", t, MSSPRDATA); end
      n_tests++; if ({S_PSEL, S_PENABLE} !== 5'b0) begin n_fail++; $display("FAIL um%0d_sel got %b exp 00000", t, {S_PSEL, S_PENABLE}); end
      end_xfer();
    end
  endtask

  task automatic test_late_ready();
    S_PREADY  = 4'b0000;
    S_PSLVERR = 4'b1000;
    S_PRDATA[96 +: 32] = 32'h3333_0015;
    start_xfer(32'h0000_0300, 1'b0, 32'h0);
    for (int k = 1; k <= 15; k++) begin
      @(posedge FAB_CLK); #1;
      S_PREADY[3] = (k == 15);
      @(negedge FAB_CLK);
      n_tests++; if ({MSSPREADY, MSSPSLVERR} !== {2{k == 15}}) begin n_fail++; $display("FAIL late_resp_c%0d got %b", k, {MSSPREADY, MSSPSLVERR}); end
    end
    n_tests++; if (MSSPRDATA !== 32'h3333_0015) begin n_fail++; $display("FAIL late_rdata got %h exp 33330015", MSSPRDATA); end
    end_xfer();
    S_PREADY = 4'b0000; S_PSLVERR = 4'b0000;
    @(negedge FAB_CLK);
    n_tests++; if (TO_FLAG !== 1'b0) begin n_fail++; $display("FAIL late_toflag got %b exp 0", TO_FLAG); end
  endtask

  task automatic test_timeout(input logic [2:0] s, input logic clr_on_abort);
    S_PREADY = 4'b0000;
    start_xfer({21'h0, s, 8'h00}, 1'b0, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge FAB_CLK); #1;
      if (k == 16) TO_CLR = clr_on_abort;
      @(negedge FAB_CLK);
      if (k < 16) begin
        n_tests++; if (MSSPREADY !== 1'b0) begin n_fail++; $display("FAIL to%0d_ready_c%0d got %b exp 0", s, k, MSSPREADY); end
      end
    end
    n_tests++; if ({MSSPREADY, MSSPSLVERR} !== 2'b11) begin n_fail++; $display("FAIL to%0d_resp got %b exp 11", s, {MSSPREADY, MSSPSLVERR}); end
    n_tests++; if (MSSPRDATA !== (32'hDEAD_0000 | 32'(s))) begin n_fail++; $display("FAIL to%0d_rdata got %h", s, MSSPRDATA); end
    n_tests++; if ({S_PSEL, S_PENABLE} !== 5'b0) begin n_fail++; $display("FAIL to%0d_sel got %b exp 00000", s, {S_PSEL, S_PENABLE}); end
    @(posedge FAB_CLK); #1;
    TO_CLR = 1'b0; MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
    n_tests++; if (TO_FLAG !== 1'b1) begin n_fail++; $display("FAIL to%0d_flag got %b exp 1", s, TO_FLAG); end
    n_tests++; if (TO_IDX !== s) begin n_fail++; $display("FAIL to%0d_idx got %0d exp %0d", s, TO_IDX, s); end
  endtask

  task automatic test_back_to_back();
    S_PREADY = 4'b0011;
    S_PRDATA[0 +: 32]  = 32'h0000_AAAA;
    S_PRDATA[32 +: 32] = 32'h1111_BBBB;
    start_xfer(32'h0000_0000, 1'b0, 32'h0);
    @(negedge FAB_CLK);
    n_tests++; if (S_PSEL !== 4'b0001) begin n_fail++; $display("FAIL b2b_a_psel got %b exp 0001", S_PSEL); end
    @(posedge FAB_CLK); #1;
    @(negedge FAB_CLK);
    n_tests++; if (MSSPREADY !== 1'b1 || MSSPRDATA !== 32'h0000_AAAA) begin n_fail++; $display("FAIL b2b_a_resp got %b/%h exp 1/0000aaaa", MSSPREADY, MSSPRDATA); end
    @(posedge FAB_CLK); #1;
    MSSPENABLE = 1'b0; MSSPADDR = 32'h0000_0100;
    @(negedge FAB_CLK);
    n_tests++; if (S_PSEL !== 4'b0000 || MSSPREADY !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got %b/%b exp 0000/0", S_PSEL, MSSPREADY); end
    @(posedge FAB_CLK); #1;
    MSSPENABLE = 1'b1;
    @(negedge FAB_CLK);
    n_tests++; if (S_PSEL !== 4'b0010) begin n_fail++; $display("FAIL b2b_b_psel got %b exp 0010", S_PSEL); end
    @(posedge FAB_CLK); #1;
    @(negedge FAB_CLK);
    n_tests++; if (MSSPREADY !== 1'b1 || MSSPRDATA !== 32'h1111_BBBB) begin n_fail++; $display("FAIL b2b_b_resp got %b/%h exp 1/1111bbbb", MSSPREADY, MSSPRDATA); end
    end_xfer();
    S_PREADY = 4'b0000;
  endtask

  task automatic test_reset_mid();
    S_PREADY = 4'b0000;
    start_xfer(32'h0000_0200, 1'b0, 32'h0);
    @(posedge FAB_CLK); #1;
    @(negedge FAB_CLK);
    n_tests++; if (S_PSEL !== 4'b0100) begin n_fail++; $display("FAIL rm_psel_pre got %b exp 0100", S_PSEL); end
    @(posedge FAB_CLK); #1;
    M2F_RESET_N = 1'b0;
    #1;
    n_tests++; if (S_PSEL !== 4'b0) begin n_fail++; $display("FAIL rm_psel got %b exp 0000", S_PSEL); end
    n_tests++; if (MSSPREADY !== 1'b0) begin n_fail++; $display("FAIL rm_ready got %b exp 0", MSSPREADY); end
    n_tests++; if (TO_FLAG !== 1'b0) begin n_fail++; $display("FAIL rm_toflag got %b exp 0", TO_FLAG); end
    @(posedge FAB_CLK); #1;
    MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
    @(posedge FAB_CLK); #1;
    M2F_RESET_N = 1'b1;
    S_PREADY = 4'b0100;
    S_PRDATA[64 +: 32] = 32'h2222_0002;
    start_xfer(32'h0000_0204, 1'b0, 32'h0);
    @(posedge FAB_CLK); #1;
    @(negedge FAB_CLK);
    n_tests++; if (MSSPREADY !== 1'b1 || MSSPRDATA !== 32'h2222_0002) begin n_fail++; $display("FAIL rm_fresh got %b/%h exp 1/22220002", MSSPREADY, MSSPRDATA); end
    end_xfer();
    S_PREADY = 4'b0000;
  endtask

  task automatic test_to_clr();
    @(posedge FAB_CLK); #1;
    TO_CLR = 1'b1;
    @(posedge FAB_CLK); #1;
    TO_CLR = 1'b0;
    n_tests++; if (TO_FLAG !== 1'b0) begin n_fail++; $display("FAIL clr_flag got %b exp 0", TO_FLAG); end
    n_tests++; if (TO_IDX !== 3'd1) begin n_fail++; $display("FAIL clr_idx got %0d exp 1", TO_IDX); end
  endtask

  initial begin
    M2F_RESET_N = 1'b0;
    MSSPSEL = 1'b0; MSSPENABLE = 1'b0; MSSPWRITE = 1'b0;
    MSSPADDR = '0; MSSPWDATA = '0;
    S_PRDATA = '0; S_PREADY = '0; S_PSLVERR = '0;
    TO_CLR = 1'b0;
    test_reset();
    test_write();
    test_wait_read();
    test_unmapped();
    test_late_ready();
    test_timeout(3'd3, 1'b0);
    test_timeout(3'd2, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_timeout(3'd1, 1'b0);
    test_to_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
